// File: rtl/psi_pow_gen.sv
// psi_pow_gen -- streaming generator of successive powers base^k mod 65537
// for the forward NTT datapath. One power is offered per cycle on a
// valid/ready interface, k = 0 .. count-1, starting from base^0 = 1.
//
// Ports:
//   clk    clock
//   rst    synchronous reset, active-high
//   start  one-cycle request to begin a sequence (honoured only in IDLE)
//   base   generator element, sampled on accepted start (reduced mod Q)
//   count  number of powers to emit (0..N), sampled on accepted start
//   value  current power base^k mod Q
//   index  exponent tag of the current value
//   valid  value/index valid
//   ready  consumer accepts value when valid & ready
//   last   high with valid on the final element (k = count-1)
//   busy   high while the sequence is running
//   done   one-cycle pulse at end of sequence
//
// Build option: define PSI_POW_GEN_BITREV_EN to emit index as the IW-bit
// bit-reversal of k (matching bit-reversed twiddle/butterfly addressing);
// otherwise index = k. The value sequence is identical in both builds.
module psi_pow_gen #(
  parameter int N  = 32,
  parameter int W  = 17,
  parameter int CW = $clog2(N + 1),
  parameter int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [W-1:0]  base,
  input  logic [CW-1:0] count,
  output logic [W-1:0]  value,
  output logic [IW-1:0] index,
  output logic          valid,
  input  logic          ready,
  output logic          last,
  output logic          busy,
  output logic          done
);

  localparam logic [W-1:0] Q = 17'd65537;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  value_q, value_d;
  logic [W-1:0]  base_q, base_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] k_q, k_d;
  logic          valid_q, valid_d;
  logic          last_q, last_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  // Modular multiply-reduce. Since 2^16 = -1 (mod 65537), a product
  // hi*2^16 + lo reduces to lo - hi; one conditional +Q fixes the sign.
  // Both operands are <= 65536 so the product is at most 2^32.
  logic [2*W-1:0] prod;
  logic [15:0]    prod_lo;
  logic [17:0]    prod_hi;
  logic [18:0]    diff;
  logic [18:0]    diff_wrap;
  logic [W-1:0]   mulmod;

  assign prod      = {{W{1'b0}}, value_q} * {{W{1'b0}}, base_q};
  assign prod_lo   = prod[15:0];
  assign prod_hi   = prod[2*W-1:16];
  assign diff      = {3'b000, prod_lo} - {1'b0, prod_hi};
  assign diff_wrap = diff + 19'd65537;
  assign mulmod    = diff[18] ? W'(diff_wrap) : W'(diff);

  // Bases at or above Q (only Q..2^17-1 are representable) need one
  // subtraction to land in [0, Q-1].
  logic [W-1:0] base_norm;
  assign base_norm = (base >= Q) ? (base - Q) : base;

  logic [CW-1:0] count_m1;
  logic [CW-1:0] k_inc;
  logic          at_last;
  assign count_m1 = count_q - CW'(1);
  assign k_inc    = k_q + CW'(1);
  assign at_last  = (k_q == count_m1);

  always_comb begin
    state_d = state_q;
    value_d = value_q;
    base_d  = base_q;
    count_d = count_q;
    k_d     = k_q;
    valid_d = valid_q;
    last_d  = last_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (count != '0) begin
            base_d  = base_norm;
            count_d = count;
            value_d = W'(1);
            k_d     = '0;
            valid_d = 1'b1;
            busy_d  = 1'b1;
            last_d  = (count == CW'(1));
            state_d = RUN;
          end else begin
            state_d = DONE;
          end
        end
      end
      RUN: begin
        // valid is always high here, so ready alone marks a handshake.
        if (ready) begin
          if (at_last) begin
            valid_d = 1'b0;
            busy_d  = 1'b0;
            last_d  = 1'b0;
            state_d = DONE;
          end else begin
            value_d = mulmod;
            k_d     = k_inc;
            last_d  = (k_inc == count_m1);
          end
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      value_q <= '0;
      base_q  <= '0;
      count_q <= '0;
      k_q     <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      base_q  <= base_d;
      count_q <= count_d;
      k_q     <= k_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef PSI_POW_GEN_BITREV_EN
  logic [IW-1:0] index_rev;
  for (genvar gi = 0; gi < IW; gi++) begin : g_bitrev
    assign index_rev[gi] = k_q[IW-1-gi];
  end
  assign index = index_rev;
`else
  assign index = k_q[IW-1:0];
`endif

  assign value = value_q;
  assign valid = valid_q;
  assign last  = last_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_psi_pow_gen.sv
// Directed bench for psi_pow_gen: hand-computed power sequences, stall,
// edge starts and mid-sequence reset.
module tb_psi_pow_gen;

  localparam int N  = 32;
  localparam int W  = 17;
  localparam int CW = 6;
  localparam int IW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  base;
  logic [CW-1:0] count;
  logic [W-1:0]  value;
  logic [IW-1:0] index;
  logic          valid;
  logic          ready;
  logic          last;
  logic          busy;
  logic          done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  psi_pow_gen #(.N(N), .W(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .base  (base),
    .count (count),
    .value (value),
    .index (index),
    .valid (valid),
    .ready (ready),
    .last  (last),
    .busy  (busy),
    .done  (done)
  );

  task automatic check(input string tag, input longint obs, input longint expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_idx(input int k);
`ifdef PSI_POW_GEN_BITREV_EN
    int r = 0;
    for (int b = 0; b < IW; b++) begin
      if (((k >> b) & 1) != 0) r |= (1 << (IW - 1 - b));
    end
    return r;
`else
    return k;
`endif
  endfunction

  // Accepted start: first value is visible on return.
  task automatic kick(input int b, input int c);
    start = 1'b1;
    base  = W'(b);
    count = CW'(c);
    step();
    start = 1'b0;
  endtask

  task automatic expect_elem(input string tag, input int v, input int idx, input bit lst);
    $display("%s: value=%0d index=%0d last=%0d", tag, value, index, last);
    check({tag, ".value"}, value, v);
    check({tag, ".index"}, index, idx);
    check({tag, ".valid"}, valid, 1);
    check({tag, ".last"},  last,  lst);
    check({tag, ".busy"},  busy,  1);
    check({tag, ".done"},  done,  0);
  endtask

  // Called right after the final handshake edge.
  task automatic expect_end(input string tag);
    check({tag, ".end_valid"}, valid, 0);
    check({tag, ".end_busy"},  busy,  0);
    check({tag, ".end_done0"}, done,  0);
    step();
    $display("%s: done=%0d", tag, done);
    check({tag, ".done"},      done,  1);
    check({tag, ".done_valid"}, valid, 0);
    step();
    check({tag, ".done_off"},  done,  0);
  endtask

  int seq256[4]   = '{1, 256, 65536, 65281};
  int seq65536[4] = '{1, 65536, 1, 65536};

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    ready = 1'b1;
    base  = '0;
    count = '0;
    step();
    step();
    check("rst.value", value, 0);
    check("rst.index", index, 0);
    check("rst.valid", valid, 0);
    check("rst.last",  last,  0);
    check("rst.busy",  busy,  0);
    check("rst.done",  done,  0);
    rst = 1'b0;
    step();

    // base 256, count 4, ready high
    kick(256, 4);
    for (int i = 0; i < 4; i++) begin
      expect_elem($sformatf("b256[%0d]", i), seq256[i], exp_idx(i), i == 3);
      step();
    end
    expect_end("b256");

    // 2^32 reduction corner
    kick(65536, 4);
    for (int i = 0; i < 4; i++) begin
      expect_elem($sformatf("b65536[%0d]", i), seq65536[i], exp_idx(i), i == 3);
      step();
    end
    expect_end("b65536");

    // base 2, full length
    begin
      longint m = 1;
      kick(2, 32);
      for (int k = 0; k < 32; k++) begin
        expect_elem($sformatf("b2[%0d]", k), int'(m), exp_idx(k), k == 31);
        if (k == 16) check("b2.k16", value, 65536);
        if (k == 31) check("b2.k31", value, 32769);
        m = (m * 2) % 65537;
        step();
      end
      expect_end("b2");
    end

    // Back-pressure: stall 3 cycles on the second element
    kick(256, 4);
    expect_elem("stall[0]", 1, exp_idx(0), 0);
    step();
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      expect_elem($sformatf("stall.hold%0d", i), 256, exp_idx(1), 0);
    end
    ready = 1'b1;
    step();
    expect_elem("stall[2]", 65536, exp_idx(2), 0);
    step();
    expect_elem("stall[3]", 65281, exp_idx(3), 1);
    step();
    expect_end("stall");

    // count = 0: no valid, done two cycles after start
    kick(5, 0);
    check("cnt0.valid", valid, 0);
    check("cnt0.busy",  busy,  0);
    check("cnt0.done0", done,  0);
    step();
    $display("cnt0: done=%0d valid=%0d", done, valid);
    check("cnt0.done",   done,  1);
    check("cnt0.valid2", valid, 0);
    step();
    check("cnt0.done_off", done, 0);

    // start during RUN and during DONE is ignored
    kick(256, 4);
    expect_elem("ign[0]", 1, exp_idx(0), 0);
    start = 1'b1;
    base  = W'(3);
    count = CW'(2);
    step();
    start = 1'b0;
    for (int i = 1; i < 4; i++) begin
      expect_elem($sformatf("ign[%0d]", i), seq256[i], exp_idx(i), i == 3);
      step();
    end
    check("ign.end_valid", valid, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    check("ign.done",       done,  1);
    check("ign.done_valid", valid, 0);
    step();
    check("ign.after_valid", valid, 0);
    check("ign.after_busy",  busy,  0);
    check("ign.after_done",  done,  0);

    // base = Q+1 behaves as 1
    kick(65538, 3);
    for (int i = 0; i < 3; i++) begin
      expect_elem($sformatf("bq1[%0d]", i), 1, exp_idx(i), i == 2);
      step();
    end
    expect_end("bq1");

    // Reset at k = 2 of a count-8 run
    kick(2, 8);
    step();
    step();
    expect_elem("mrst[2]", 4, exp_idx(2), 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    $display("mrst: valid=%0d busy=%0d value=%0d", valid, busy, value);
    check("mrst.valid", valid, 0);
    check("mrst.busy",  busy,  0);
    check("mrst.value", value, 0);
    check("mrst.index", index, 0);
    check("mrst.last",  last,  0);
    check("mrst.done",  done,  0);
    step();
    check("mrst.nodone", done, 0);
    kick(256, 2);
    expect_elem("post[0]", 1,   exp_idx(0), 0);
    step();
    expect_elem("post[1]", 256, exp_idx(1), 1);
    step();
    expect_end("post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
